// File: rtl/nanov_spi_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : nanov_spi_fetch_if
// Purpose  : SPI flash pins plus the instruction valid/ready and jump bus
//            between the nanoV fetcher (master) and core/flash (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface nanov_spi_fetch_if;
  logic        spi_select;
  logic        spi_clk_out;
  logic        spi_mosi;
  logic        spi_miso;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [23:0] pc;
  logic        jump_en;
  logic [23:0] jump_addr;

  modport master (
    output spi_select, spi_clk_out, spi_mosi,
    input  spi_miso,
    output instr, instr_valid, pc,
    input  instr_ready, jump_en, jump_addr
  );

  modport slave (
    input  spi_select, spi_clk_out, spi_mosi,
    output spi_miso,
    input  instr, instr_valid, pc,
    output instr_ready, jump_en, jump_addr
  );
endinterface
`default_nettype wire

// File: rtl/nanov_spi_fetch.sv
`default_nettype none
// ============================================================================
// Module   : nanov_spi_fetch
// Purpose  : SPI flash READ instruction streamer; assembles little-endian
//            32-bit words for the nanoV core. Define NANOV_FETCH_PREFETCH_EN
//            to add a one-word holding buffer behind instr.
// Revision : 1.0 - initial release
// ============================================================================
module nanov_spi_fetch #(
  parameter logic [7:0]  READ_CMD       = 8'h03,
  parameter logic [23:0] RESET_ADDR     = 24'h000000,
  parameter int unsigned CS_HIGH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rstn,
  nanov_spi_fetch_if.master fetch_bus
);

  localparam int unsigned           c_CS_W    = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;
  localparam logic [c_CS_W-1:0]     c_CS_LAST = c_CS_W'(CS_HIGH_CYCLES - 1);

  localparam logic [2:0] c_ST_DESELECT = 3'd0;
  localparam logic [2:0] c_ST_CMD      = 3'd1;
  localparam logic [2:0] c_ST_ADDR     = 3'd2;
  localparam logic [2:0] c_ST_DATA     = 3'd3;
  localparam logic [2:0] c_ST_STALL    = 3'd4;

  logic [2:0]        r_state;
  logic              r_phase;
  logic [4:0]        r_bitcnt;
  logic [c_CS_W-1:0] r_cs_cnt;
  logic [31:0]       r_tx;
  logic [31:0]       r_shift;
  logic [31:0]       r_instr;
  logic [23:0]       r_pc;
  logic [23:0]       r_fetch_addr;
  logic              r_valid;
`ifdef NANOV_FETCH_PREFETCH_EN
  logic [31:0]       r_buf;
  logic [23:0]       r_buf_pc;
  logic              r_buf_valid;
`endif

  logic        w_shifting;
  logic        w_word_done;
  logic        w_consume;
  logic        w_space;
  logic        w_push;
  logic [31:0] w_raw;
  logic [31:0] w_word;
  logic [23:0] w_jump_addr;

  assign w_shifting  = (r_state == c_ST_CMD) || (r_state == c_ST_ADDR) || (r_state == c_ST_DATA);
  // A stalled word sits complete in r_shift; otherwise the last bit comes straight off MISO.
  assign w_word_done = ((r_state == c_ST_DATA) && r_phase && (r_bitcnt == 5'd31)) || (r_state == c_ST_STALL);
  assign w_raw       = (r_state == c_ST_STALL) ? r_shift : {r_shift[30:0], fetch_bus.spi_miso};
  assign w_word      = {w_raw[7:0], w_raw[15:8], w_raw[23:16], w_raw[31:24]};
  assign w_consume   = r_valid & fetch_bus.instr_ready;
`ifdef NANOV_FETCH_PREFETCH_EN
  assign w_space     = !r_buf_valid || w_consume;
`else
  assign w_space     = !r_valid || w_consume;
`endif
  assign w_push      = w_word_done & w_space;
  assign w_jump_addr = fetch_bus.jump_addr & ~24'h3;

  assign fetch_bus.spi_select  = (r_state == c_ST_DESELECT);
  assign fetch_bus.spi_clk_out = w_shifting & r_phase;
  assign fetch_bus.spi_mosi    = ((r_state == c_ST_CMD) || (r_state == c_ST_ADDR)) & r_tx[31];
  assign fetch_bus.instr       = r_instr;
  assign fetch_bus.instr_valid = r_valid;
  assign fetch_bus.pc          = r_pc;

  always_ff @(posedge clk) begin
    if (rstn || fetch_bus.jump_en) begin
      r_state  <= c_ST_DESELECT;
      r_phase  <= 1'b0;
      r_bitcnt <= 5'd0;
      r_cs_cnt <= '0;
      r_tx     <= 32'd0;
      r_shift  <= 32'd0;
    end else begin
      case (r_state)
        c_ST_DESELECT: begin
          if (r_cs_cnt == c_CS_LAST) begin
            r_state  <= c_ST_CMD;
            r_tx     <= {READ_CMD, r_fetch_addr};
            r_phase  <= 1'b0;
            r_bitcnt <= 5'd0;
          end else begin
            r_cs_cnt <= r_cs_cnt + c_CS_W'(1);
          end
        end
        c_ST_CMD, c_ST_ADDR, c_ST_DATA: begin
          r_phase <= ~r_phase;
          if (r_phase) begin
            r_tx     <= {r_tx[30:0], 1'b0};
            r_shift  <= {r_shift[30:0], fetch_bus.spi_miso};
            r_bitcnt <= r_bitcnt + 5'd1;
            if ((r_state == c_ST_CMD) && (r_bitcnt == 5'd7)) begin
              r_state  <= c_ST_ADDR;
              r_bitcnt <= 5'd0;
            end
            if ((r_state == c_ST_ADDR) && (r_bitcnt == 5'd23)) begin
              r_state  <= c_ST_DATA;
              r_bitcnt <= 5'd0;
            end
            if ((r_state == c_ST_DATA) && (r_bitcnt == 5'd31) && !w_space) begin
              r_state <= c_ST_STALL;
            end
          end
        end
        c_ST_STALL: begin
          if (w_space) begin
            r_state <= c_ST_DATA;
          end
        end
        default: r_state <= c_ST_DESELECT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_instr      <= 32'd0;
      r_pc         <= RESET_ADDR;
      r_valid      <= 1'b0;
      r_fetch_addr <= RESET_ADDR;
`ifdef NANOV_FETCH_PREFETCH_EN
      r_buf        <= 32'd0;
      r_buf_pc     <= RESET_ADDR;
      r_buf_valid  <= 1'b0;
`endif
    end else if (fetch_bus.jump_en) begin
      r_valid      <= 1'b0;
      r_fetch_addr <= w_jump_addr;
`ifdef NANOV_FETCH_PREFETCH_EN
      r_buf_valid  <= 1'b0;
`endif
    end else begin
      if (w_push) begin
        r_fetch_addr <= r_fetch_addr + 24'd4;
      end
`ifdef NANOV_FETCH_PREFETCH_EN
      // instr is the queue head, r_buf the tail; a consume shifts the tail forward.
      if (w_consume) begin
        if (r_buf_valid) begin
          r_instr     <= r_buf;
          r_pc        <= r_buf_pc;
          r_buf_valid <= w_push;
          if (w_push) begin
            r_buf    <= w_word;
            r_buf_pc <= r_fetch_addr;
          end
        end else if (w_push) begin
          r_instr <= w_word;
          r_pc    <= r_fetch_addr;
        end else begin
          r_valid <= 1'b0;
        end
      end else if (w_push) begin
        if (!r_valid) begin
          r_instr <= w_word;
          r_pc    <= r_fetch_addr;
          r_valid <= 1'b1;
        end else begin
          r_buf       <= w_word;
          r_buf_pc    <= r_fetch_addr;
          r_buf_valid <= 1'b1;
        end
      end
`else
      if (w_push) begin
        r_instr <= w_word;
        r_pc    <= r_fetch_addr;
        r_valid <= 1'b1;
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nanov_spi_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_nanov_spi_fetch
// Purpose  : Directed plus randomized bench for nanov_spi_fetch with a
//            behavioural SPI flash and an address-ordered word scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nanov_spi_fetch;

  logic clk;
  logic rstn;
  nanov_spi_fetch_if bus ();

  nanov_spi_fetch dut (
    .clk       (clk),
    .rstn      (rstn),
    .fetch_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          n_consumed = 0;
  logic [23:0] exp_pc = 24'd0;
  logic [7:0]  seed8;

  // Flash contents: fixed program words at 0..7, pseudo-random bytes elsewhere.
  function automatic logic [7:0] fb(input logic [23:0] a);
    logic [7:0] h;
    case (a)
      24'd0:   h = 8'h13;
      24'd4:   h = 8'h93;
      24'd6:   h = 8'h10;
      24'd1, 24'd2, 24'd3, 24'd5, 24'd7: h = 8'h00;
      default: h = (a[7:0] * 8'd37) ^ (a[15:8] + a[23:16]) ^ seed8;
    endcase
    return h;
  endfunction

  function automatic logic [31:0] word_at(input logic [23:0] a);
    return {fb(a + 24'd3), fb(a + 24'd2), fb(a + 24'd1), fb(a)};
  endfunction

  // Mode-0 SPI flash: samples MOSI on SCK rise, drives MISO on SCK fall.
  int          fl_cnt = 0;
  logic [31:0] fl_sh  = 32'd0;
  logic [7:0]  fl_cmd = 8'd0;
  logic [23:0] fl_addr = 24'd0;
  always @(posedge bus.spi_clk_out or negedge bus.spi_clk_out or posedge bus.spi_select) begin : flash_model
    int         idx;
    logic [7:0] b;
    if (bus.spi_select === 1'b1) begin
      fl_cnt = 0;
    end else if (bus.spi_clk_out === 1'b1) begin
      if (fl_cnt < 32) fl_sh = {fl_sh[30:0], bus.spi_mosi};
      fl_cnt++;
      if (fl_cnt == 32) begin
        fl_cmd  = fl_sh[31:24];
        fl_addr = fl_sh[23:0];
      end
    end else if (fl_cnt >= 32) begin
      idx = fl_cnt - 32;
      b   = fb(fl_addr + 24'(idx >> 3));
      bus.spi_miso = b[7 - (idx % 8)];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Score the current cycle's consume (if any), then advance to the next negedge.
  task automatic tick();
    if (!rstn && !bus.jump_en && bus.instr_valid === 1'b1 && bus.instr_ready) begin
      check("sb_pc", {8'h00, bus.pc}, {8'h00, exp_pc});
      check("sb_instr", bus.instr, word_at(exp_pc));
      exp_pc = exp_pc + 24'd4;
      n_consumed++;
    end
    @(negedge clk);
  endtask

  task automatic wait_valid(input int lim, output int n);
    n = 0;
    while (bus.instr_valid !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    if (bus.instr_valid !== 1'b1) check("valid_timeout", {31'd0, bus.instr_valid}, 32'd1);
  endtask

  task automatic count_cs_high(output int n);
    n = 0;
    while (bus.spi_select !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          m;
    int          n;
    int          base;
    logic [23:0] ja;
    logic [23:0] jb;

    seed8         = 8'($urandom);
    rstn          = 1'b1;
    bus.spi_miso  = 1'b0;
    bus.instr_ready = 1'b0;
    bus.jump_en   = 1'b0;
    bus.jump_addr = 24'd0;
    repeat (3) @(negedge clk);

    // Reset values and first-word latency
    check("rst_select", {31'd0, bus.spi_select}, 32'd1);
    check("rst_sck", {31'd0, bus.spi_clk_out}, 32'd0);
    check("rst_mosi", {31'd0, bus.spi_mosi}, 32'd0);
    check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_instr", bus.instr, 32'd0);
    check("rst_pc", {8'h00, bus.pc}, 32'd0);
    rstn = 1'b0;
    exp_pc = 24'd0;
    count_cs_high(n);
    check("cs_low_cycle", n, 2);
    wait_valid(300, m);
    check("first_valid_cycle", n + m, 130);
    check("first_instr", bus.instr, 32'h00000013);
    check("first_pc", {8'h00, bus.pc}, 32'd0);
    check("first_cmd", {24'd0, fl_cmd}, 32'h03);
    check("first_addr", {8'h00, fl_addr}, 32'd0);

    // Back-to-back stream: second word exactly one word time later
    bus.instr_ready = 1'b1;
    tick();
    wait_valid(200, m);
    check("second_gap", m + 1, 64);
    check("second_instr", bus.instr, 32'h00100093);
    check("second_pc", {8'h00, bus.pc}, 32'h4);

    // Back-pressure: SCK parks low with CS asserted and no bits lost
    rstn = 1'b1;
    bus.instr_ready = 1'b0;
    tick();
    tick();
    rstn = 1'b0;
    exp_pc = 24'd0;
    wait_valid(300, m);
    repeat (200) tick();
    check("stall_sck", {31'd0, bus.spi_clk_out}, 32'd0);
    check("stall_cs", {31'd0, bus.spi_select}, 32'd0);
`ifdef NANOV_FETCH_PREFETCH_EN
    check("stall_bits", fl_cnt, 128);
`else
    check("stall_bits", fl_cnt, 96);
`endif
    check("stall_pc_hold", {8'h00, bus.pc}, 32'd0);
    bus.instr_ready = 1'b1;
    base = n_consumed;
    n = 0;
    while (n_consumed < base + 3 && n < 400) begin
      tick();
      n++;
    end
    check("stall_resume_words", n_consumed - base, 3);

    // Jump mid-DATA to an unaligned target
    n = 0;
    while (!(bus.spi_select === 1'b0 && fl_cnt >= 32 && (fl_cnt % 32) == 10) && n < 200) begin
      tick();
      n++;
    end
    bus.jump_en = 1'b1;
    bus.jump_addr = 24'h000103;
    exp_pc = 24'h000100;
    tick();
    bus.jump_en = 1'b0;
    check("jump_cs", {31'd0, bus.spi_select}, 32'd1);
    check("jump_sck", {31'd0, bus.spi_clk_out}, 32'd0);
    check("jump_valid", {31'd0, bus.instr_valid}, 32'd0);
    count_cs_high(n);
    check("jump_cs_high", n, 2);
    wait_valid(300, m);
    check("jump_latency", n + m, 130);
    check("jump_pc", {8'h00, bus.pc}, 32'h100);
    check("jump_cmd", {24'd0, fl_cmd}, 32'h03);
    check("jump_flash_addr", {8'h00, fl_addr}, 32'h100);

    // Jump coinciding with a consume and a completing word
    bus.instr_ready = 1'b0;
    repeat (63) tick();
    ja = 24'($urandom) | 24'h3;
    bus.instr_ready = 1'b1;
    bus.jump_en = 1'b1;
    bus.jump_addr = ja;
    exp_pc = ja & ~24'h3;
    tick();
    bus.jump_en = 1'b0;
    check("jc_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("jc_cs", {31'd0, bus.spi_select}, 32'd1);
    wait_valid(300, m);
    check("jc_pc", {8'h00, bus.pc}, {8'h00, exp_pc});
    check("jc_instr", bus.instr, word_at(exp_pc));

    // Repeated jumps in DESELECT: latest address wins, CS count restarts
    bus.instr_ready = 1'b0;
    ja = 24'h200000 | (24'($urandom) & 24'h0FFFFC);
    jb = 24'h400000 | (24'($urandom) & 24'h0FFFFC);
    bus.jump_en = 1'b1;
    bus.jump_addr = ja;
    tick();
    bus.jump_addr = jb;
    exp_pc = jb;
    tick();
    bus.jump_en = 1'b0;
    count_cs_high(n);
    check("rejump_cs_high", n, 2);
    wait_valid(300, m);
    check("rejump_pc", {8'h00, bus.pc}, {8'h00, jb});
    check("rejump_flash_addr", {8'h00, fl_addr}, {8'h00, jb});

    // Reset asserted during the ADDR phase
    ja = 24'h600000 | (24'($urandom) & 24'h0FFFFC);
    bus.jump_en = 1'b1;
    bus.jump_addr = ja;
    exp_pc = ja;
    tick();
    bus.jump_en = 1'b0;
    n = 0;
    while (!(bus.spi_select === 1'b0 && fl_cnt == 16) && n < 100) begin
      tick();
      n++;
    end
    rstn = 1'b1;
    exp_pc = 24'd0;
    tick();
    check("rst_addr_cs", {31'd0, bus.spi_select}, 32'd1);
    check("rst_addr_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_addr_pc", {8'h00, bus.pc}, 32'd0);
    rstn = 1'b0;
    count_cs_high(n);
    wait_valid(300, m);
    check("rst_addr_latency", n + m, 130);
    check("rst_addr_instr", bus.instr, 32'h00000013);
    check("rst_addr_flash", {8'h00, fl_addr}, 32'd0);

    // Address wrap from the top of flash
    bus.instr_ready = 1'b1;
    bus.jump_en = 1'b1;
    bus.jump_addr = 24'hFFFFFD;
    exp_pc = 24'hFFFFFC;
    tick();
    bus.jump_en = 1'b0;
    wait_valid(300, m);
    check("wrap_pc_top", {8'h00, bus.pc}, 32'hFFFFFC);
    tick();
    wait_valid(200, m);
    check("wrap_pc_zero", {8'h00, bus.pc}, 32'd0);
    check("wrap_instr_zero", bus.instr, 32'h00000013);

    // Randomized back-pressure and jumps against the scoreboard
    base = n_consumed;
    for (int i = 0; i < 4000; i++) begin
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      if (bus.jump_en) begin
        bus.jump_en = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        ja = ($urandom_range(0, 1) != 0) ? 24'($urandom) : (24'hFFFFE0 | 24'($urandom_range(0, 31)));
        bus.jump_en = 1'b1;
        bus.jump_addr = ja;
        exp_pc = ja & ~24'h3;
      end
      tick();
    end
    bus.jump_en = 1'b0;
    check("rand_progress", {31'd0, (n_consumed - base) > 10}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
